// File: rtl/ram256_pkg.sv
// Shared types and constants for the 256x32 RAM access controller.
// The RAM is built from four 64-word banks.
package ram256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    localparam int NUM_BANKS  = 4;
    localparam int BANK_DEPTH = 64;
    localparam int BANK_SEL_W = 2;
    localparam int ADDR_BITS  = 8;

    // The top address bits pick the bank; the rest address a word inside it.
    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [ADDR_BITS-1:0] addr);
        return addr[ADDR_BITS-1 -: BANK_SEL_W];
    endfunction

endpackage

// File: rtl/ram256_addr_dec.sv
// Splits a word address into a one-hot bank strobe and the shared in-bank address.
module ram256_addr_dec
    import ram256_pkg::*;
#(
    parameter int ADDR_W  = ADDR_BITS,
    parameter int BANK_AW = $clog2(BANK_DEPTH)
) (
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 en_i,
    input  logic                 we_i,
    output logic [NUM_BANKS-1:0] bank_en_o,
    output logic [NUM_BANKS-1:0] bank_we_o,
    output logic [BANK_AW-1:0]   bank_addr_o
);

    logic [NUM_BANKS-1:0] one_hot;

    assign one_hot     = NUM_BANKS'(1) << bank_of(addr_i);
    assign bank_en_o   = en_i ? one_hot : '0;
    assign bank_we_o   = (en_i && we_i) ? one_hot : '0;
    assign bank_addr_o = addr_i[BANK_AW-1:0];

endmodule

// File: rtl/ram256_ctrl.sv
// Single-word access controller for the four-bank 256x32 RAM.
// It keeps the output-mux select aligned with the bank read latency and registers the read data.
module ram256_ctrl
    import ram256_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int BANK_AW = 6,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [NUM_BANKS-1:0]  bank_en,
    output logic [NUM_BANKS-1:0]  bank_we,
    output logic [BANK_AW-1:0]    bank_addr,
    output logic [DATA_W-1:0]     bank_wdata,
    output logic [BANK_SEL_W-1:0] mux_sel,
    input  logic [DATA_W-1:0]     mux_y,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    we_q, we_d;
    logic                    ready_q, ready_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [BANK_SEL_W-1:0]   sel_q, sel_d;

    // Bank strobes are decoded from the current state so a reset removes them at once.
    ram256_addr_dec #(
        .ADDR_W  (ADDR_W),
        .BANK_AW (BANK_AW)
    ) u_addr_dec (
        .addr_i      (addr_q),
        .en_i        (state_q == ACCESS),
        .we_i        (we_q),
        .bank_en_o   (bank_en),
        .bank_we_o   (bank_we),
        .bank_addr_o (bank_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    sel_d   = bank_of(req_addr);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            // Data from the selected bank reaches the mux on the last WAIT cycle.
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = mux_y;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    assign req_ready  = ready_q;
    assign bank_wdata = wdata_q;
    assign mux_sel    = sel_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign busy       = (state_q != IDLE);

    // Bank strobes stay one-hot-or-zero and only appear in the ACCESS cycle.
    assert property (@(posedge clk) disable iff (rst) $onehot0(bank_en) && $onehot0(bank_we));
    assert property (@(posedge clk) disable iff (rst) (state_q != ACCESS) |-> (bank_en == '0));

endmodule

// File: tb/tb_ram256_ctrl.sv
// Directed bench for ram256_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3,
// each with a small bank/mux model behind it.
module tb_ram256_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWe     [2];
    logic [7:0]  reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic [3:0]  bankEn    [2];
    logic [3:0]  bankWe    [2];
    logic [5:0]  bankAddr  [2];
    logic [31:0] bankWdata [2];
    logic [1:0]  muxSel    [2];
    logic [31:0] muxY      [2];
    logic        rspValid  [2];
    logic [31:0] rspRdata  [2];
    logic        busy      [2];

    int compareCount = 0;
    int errorCount   = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] encodeBank(input logic [3:0] oneHot);
        case (oneHot)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Each instance gets four banks with a read pipeline RD_LAT deep and a 4:1 output mux.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] mem      [256];
        logic [31:0] rdPipe   [3];
        logic [1:0]  bankPipe [3];
        bit   [2:0]  vPipe;

        ram256_ctrl #(
            .DATA_W  (32),
            .ADDR_W  (8),
            .BANK_AW (6),
            .RD_LAT  (LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (reqValid[g]),
            .req_ready  (reqReady[g]),
            .req_we     (reqWe[g]),
            .req_addr   (reqAddr[g]),
            .req_wdata  (reqWdata[g]),
            .bank_en    (bankEn[g]),
            .bank_we    (bankWe[g]),
            .bank_addr  (bankAddr[g]),
            .bank_wdata (bankWdata[g]),
            .mux_sel    (muxSel[g]),
            .mux_y      (muxY[g]),
            .rsp_valid  (rspValid[g]),
            .rsp_rdata  (rspRdata[g]),
            .busy       (busy[g])
        );

        always @(posedge clk) begin
            if (bankWe[g] != 4'b0000)
                mem[{encodeBank(bankWe[g]), bankAddr[g]}] <= bankWdata[g];
            vPipe       <= {vPipe[1:0], (bankEn[g] != 4'b0000) && (bankWe[g] == 4'b0000)};
            rdPipe[0]   <= mem[{encodeBank(bankEn[g]), bankAddr[g]}];
            bankPipe[0] <= encodeBank(bankEn[g]);
            for (int k = 1; k < 3; k++) begin
                rdPipe[k]   <= rdPipe[k-1];
                bankPipe[k] <= bankPipe[k-1];
            end
        end

        assign muxY[g] = (vPipe[LAT-1] && (muxSel[g] == bankPipe[LAT-1])) ? rdPipe[LAT-1]
                                                                         : 32'hBAD0_BAD0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input int idx);
        checkOutput("rst_bank_en",    32'(bankEn[idx]),    32'd0);
        checkOutput("rst_bank_we",    32'(bankWe[idx]),    32'd0);
        checkOutput("rst_bank_addr",  32'(bankAddr[idx]),  32'd0);
        checkOutput("rst_bank_wdata", bankWdata[idx],      32'd0);
        checkOutput("rst_mux_sel",    32'(muxSel[idx]),    32'd0);
        checkOutput("rst_rsp_valid",  32'(rspValid[idx]),  32'd0);
        checkOutput("rst_rsp_rdata",  rspRdata[idx],       32'd0);
        checkOutput("rst_busy",       32'(busy[idx]),      32'd0);
        checkOutput("rst_req_ready",  32'(reqReady[idx]),  32'd0);
    endtask

    // One complete request on instance idx, checked cycle by cycle through the response.
    task automatic applyStimulus(input int idx, input logic we, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [31:0] expRdata);
        int         lat;
        int         n;
        logic [1:0] bank;
        logic [3:0] oneHot;
        lat    = (idx == 0) ? 1 : 3;
        bank   = addr[7:6];
        oneHot = 4'b0001 << bank;

        @(negedge clk);
        reqValid[idx] = 1'b1;
        reqWe[idx]    = we;
        reqAddr[idx]  = addr;
        reqWdata[idx] = data;
        checkOutput("idle_ready", 32'(reqReady[idx]), 32'd1);

        @(posedge clk);
        @(negedge clk);
        reqValid[idx] = 1'b0;
        checkOutput("access_en",    32'(bankEn[idx]),   32'(oneHot));
        checkOutput("access_we",    32'(bankWe[idx]),   we ? 32'(oneHot) : 32'd0);
        checkOutput("access_addr",  32'(bankAddr[idx]), 32'(addr[5:0]));
        checkOutput("access_sel",   32'(muxSel[idx]),   32'(bank));
        checkOutput("access_ready", 32'(reqReady[idx]), 32'd0);
        checkOutput("access_busy",  32'(busy[idx]),     32'd1);
        if (we)
            checkOutput("access_wdata", bankWdata[idx], data);

        n = 1;
        while (n < 12 && !rspValid[idx]) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (!rspValid[idx]) begin
                checkOutput("wait_en",    32'(bankEn[idx]),   32'd0);
                checkOutput("wait_sel",   32'(muxSel[idx]),   32'(bank));
                checkOutput("wait_ready", 32'(reqReady[idx]), 32'd0);
            end
        end
        checkOutput("rsp_latency", 32'(n), we ? 32'd2 : 32'(2 + lat));
        checkOutput("rsp_rdata",   rspRdata[idx],       expRdata);
        checkOutput("rsp_en",      32'(bankEn[idx]),    32'd0);
        checkOutput("rsp_ready",   32'(reqReady[idx]),  32'd0);

        @(posedge clk);
        @(negedge clk);
        checkOutput("post_valid", 32'(rspValid[idx]), 32'd0);
        checkOutput("post_ready", 32'(reqReady[idx]), 32'd1);
        checkOutput("post_busy",  32'(busy[idx]),     32'd0);
        checkOutput("post_sel",   32'(muxSel[idx]),   32'(bank));
    endtask

    // Requester keeps req_valid high and advances to the next write only once accepted.
    task automatic runBackToBack();
        logic [7:0] addrs [4];
        int         accepts;
        int         writes;
        int         lastAcc;
        logic       accepted;
        addrs   = '{8'h00, 8'h40, 8'h80, 8'hC0};
        accepts = 0;
        writes  = 0;
        lastAcc = -1;

        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWe[0]    = 1'b1;
        reqAddr[0]  = addrs[0];
        reqWdata[0] = 32'hB2B0_0000;
        for (int cyc = 0; cyc < 20; cyc++) begin
            accepted = reqValid[0] && reqReady[0];
            if (accepted) begin
                if (lastAcc >= 0)
                    checkOutput("b2b_gap", 32'(cyc - lastAcc), 32'd3);
                lastAcc = cyc;
                accepts++;
            end
            if (bankWe[0] != 4'b0000) begin
                if (writes < 4) begin
                    checkOutput("b2b_we",    32'(bankWe[0]), 32'(1) << writes);
                    checkOutput("b2b_wdata", bankWdata[0],   32'hB2B0_0000 + 32'(writes));
                end
                writes++;
            end
            @(posedge clk);
            @(negedge clk);
            if (accepted) begin
                if (accepts < 4) begin
                    reqAddr[0]  = addrs[accepts];
                    reqWdata[0] = 32'hB2B0_0000 + 32'(accepts);
                end else begin
                    reqValid[0] = 1'b0;
                end
            end
        end
        checkOutput("b2b_accepts", 32'(accepts), 32'd4);
        checkOutput("b2b_writes",  32'(writes),  32'd4);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawRsp;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0;
            reqWe[i]    = 1'b0;
            reqAddr[i]  = 8'h00;
            reqWdata[i] = 32'h0;
        end

        #12;
        checkResetState(0);
        checkResetState(1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("release_ready", 32'(reqReady[i]), 32'd1);
            checkOutput("release_busy",  32'(busy[i]),     32'd0);
        end

        $display("[TB] RD_LAT=1 directed accesses");
        applyStimulus(0, 1'b1, 8'h41, 32'hDEAD_BEEF, 32'h0000_0000);
        applyStimulus(0, 1'b1, 8'hFF, 32'hCAFE_F00D, 32'h0000_0000);
        applyStimulus(0, 1'b0, 8'hFF, 32'h0,         32'hCAFE_F00D);
        applyStimulus(0, 1'b1, 8'h00, 32'h1234_5678, 32'hCAFE_F00D);
        applyStimulus(0, 1'b0, 8'h41, 32'h0,         32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 8'h00, 32'h0,         32'h1234_5678);

        $display("[TB] RD_LAT=3 bank boundary accesses");
        applyStimulus(1, 1'b1, 8'h3F, 32'h3F3F_3F3F, 32'h0000_0000);
        applyStimulus(1, 1'b1, 8'h40, 32'h4040_4040, 32'h0000_0000);
        applyStimulus(1, 1'b0, 8'h3F, 32'h0,         32'h3F3F_3F3F);
        applyStimulus(1, 1'b0, 8'h40, 32'h0,         32'h4040_4040);

        $display("[TB] back-to-back writes");
        runBackToBack();

        $display("[TB] reset during a write strobe");
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWe[0]    = 1'b1;
        reqAddr[0]  = 8'h80;
        reqWdata[0] = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        checkOutput("pre_rst_we", 32'(bankWe[0]), 32'b0100);
        #2 rst = 1'b1;
        #1 checkResetState(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rerelease_ready", 32'(reqReady[0]), 32'd1);
        applyStimulus(0, 1'b0, 8'h80, 32'h0, 32'hB2B0_0002);

        $display("[TB] reset during a read wait");
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWe[1]    = 1'b0;
        reqAddr[1]  = 8'h3F;
        @(posedge clk);
        @(negedge clk);
        reqValid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy[1]), 32'd1);
        #2 rst = 1'b1;
        #1 checkResetState(1);
        @(negedge clk);
        rst = 1'b0;
        sawRsp = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (rspValid[1]) sawRsp = 1'b1;
        end
        checkOutput("abort_no_rsp", 32'(sawRsp),      32'd0);
        checkOutput("abort_rdata",  rspRdata[1],      32'd0);
        checkOutput("abort_busy0",  32'(busy[1]),     32'd0);
        checkOutput("abort_ready",  32'(reqReady[1]), 32'd1);
        applyStimulus(1, 1'b0, 8'h40, 32'h0,         32'h4040_4040);
        applyStimulus(1, 1'b1, 8'hC5, 32'h5555_AAAA, 32'h4040_4040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule
